// File: rtl/mul_add_row_pkg.sv
`timescale 1ns/1ps
// Shared widths and FSM encoding for the Montgomery row sequencer (mul_add_row).
package mul_add_row_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int DEF_NUM_WORDS = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_LAST  = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_add_row_if.sv
`timescale 1ns/1ps
// Row sequencer bus: controller handshake plus the shared B/T operand RAM ports.
interface mul_add_row_if
  import mul_add_row_pkg::*;
#(
  parameter int WORD_W = DATA_WIDTH,
  parameter int IDX_W  = 7
);

  // start is accepted only while busy is low; busy then stays high through the
  // one-cycle done pulse. RAM read data returns one cycle after rd_en.
  logic              start;
  logic [WORD_W-1:0] a_i;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_addr;
  logic [WORD_W-1:0] b_rdata;
  logic [WORD_W-1:0] t_rdata;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] carry_out;
  state_e            dbg_state;

  modport master (
    output start, a_i, b_rdata, t_rdata,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, carry_out, dbg_state
  );

  modport slave (
    input  start, a_i, b_rdata, t_rdata,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, carry_out, dbg_state
  );

endinterface

// File: rtl/mul_add_row_mul_add.sv
`timescale 1ns/1ps
// MulAdd cell: {c, s} = x*y + z + last_c, which always fits in 2*WORD_W bits.
module mul_add_row_mul_add #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] z,
  input  logic [WORD_W-1:0] last_c,
  output logic [WORD_W-1:0] s,
  output logic [WORD_W-1:0] c
);

  logic [2*WORD_W-1:0] full;

  always_comb begin
    full = ({{WORD_W{1'b0}}, x} * {{WORD_W{1'b0}}, y})
         + {{WORD_W{1'b0}}, z}
         + {{WORD_W{1'b0}}, last_c};
  end

  assign s = full[WORD_W-1:0];
  assign c = full[2*WORD_W-1:WORD_W];

endmodule

// File: rtl/mul_add_row.sv
`timescale 1ns/1ps
// Word-serial row sequencer computing T + a_i*B through one MulAdd cell.
// Define MUL_ADD_ROW_ACC_EN to accumulate t_rdata; otherwise z is 0 (first MonPro row).
module mul_add_row
  import mul_add_row_pkg::*;
#(
  parameter int WORD_W    = DATA_WIDTH,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int IDX_W     = idx_width(NUM_WORDS)
) (
  input logic         clk,
  input logic         reset,
  mul_add_row_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0]  wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] carry_q, carry_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [WORD_W-1:0] carry_out_q, carry_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;

  logic [WORD_W-1:0] z_w;
  logic [WORD_W-1:0] s_w;
  logic [WORD_W-1:0] c_w;

`ifdef MUL_ADD_ROW_ACC_EN
  assign z_w = bus.t_rdata;
`else
  logic unused_t_rdata;
  assign z_w            = '0;
  assign unused_t_rdata = ^bus.t_rdata;
`endif

  mul_add_row_mul_add #(
    .WORD_W(WORD_W)
  ) u_mul_add (
    .x      (a_q),
    .y      (bus.b_rdata),
    .z      (z_w),
    .last_c (carry_q),
    .s      (s_w),
    .c      (c_w)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    a_d         = a_q;
    carry_d     = carry_q;
    wr_data_d   = wr_data_q;
    carry_out_d = carry_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_FETCH;
          a_d       = bus.a_i;
          carry_d   = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      ST_FETCH: begin
        // Word 0 data arrives next cycle; prefetch word 1 alongside it.
        state_d = ST_RUN;
        rd_en_d = (NUM_WORDS > 1);
        if (rd_en_d) rd_addr_d = IDX_W'(1);
      end
      ST_RUN: begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q;
        wr_data_d = s_w;
        carry_d   = c_w;
        if (idx_q == LAST_IDX) begin
          state_d     = ST_LAST;
          done_d      = 1'b1;
          carry_out_d = c_w;
        end else begin
          // Reads run one word ahead of the data being consumed.
          idx_d   = idx_q + IDX_W'(1);
          rd_en_d = (idx_d != LAST_IDX);
          if (rd_en_d) rd_addr_d = idx_q + IDX_W'(2);
        end
      end
      ST_LAST: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      a_q         <= '0;
      carry_q     <= '0;
      wr_data_q   <= '0;
      carry_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      a_q         <= a_d;
      carry_q     <= carry_d;
      wr_data_q   <= wr_data_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.carry_out = carry_out_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mul_add_row.sv
`timescale 1ns/1ps
// Bench for mul_add_row: synchronous B/T RAM models, arithmetic row model, scoreboard.
module tb_mul_add_row;
  import mul_add_row_pkg::*;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 4;
  localparam int IDX_W     = 2;
  localparam int EW        = IDX_W + WORD_W;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [WORD_W-1:0] b_mem  [NUM_WORDS];
  logic [WORD_W-1:0] t_mem  [NUM_WORDS];
  logic [WORD_W-1:0] t_init [NUM_WORDS];
  logic              load_req;

  logic [EW-1:0]     exp_q[$];
  logic [WORD_W-1:0] exp_carry;

  mul_add_row_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) bus ();

  mul_add_row #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- RAM models ----------------
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      bus.b_rdata <= b_mem[bus.rd_addr];
      bus.t_rdata <= t_mem[bus.rd_addr];
    end
    if (bus.wr_en === 1'b1) t_mem[bus.wr_addr] <= bus.wr_data;
    if (load_req) begin
      for (int k = 0; k < NUM_WORDS; k++) t_mem[k] <= t_init[k];
    end
  end

  // ---------------- reference model ----------------
  task automatic model_row(input logic [WORD_W-1:0] a);
    logic [2*WORD_W-1:0] full;
    logic [WORD_W-1:0]   carry;
    carry = '0;
    exp_q.delete();
    for (int j = 0; j < NUM_WORDS; j++) begin
      full = 64'(a) * 64'(b_mem[j]) + 64'(carry);
`ifdef MUL_ADD_ROW_ACC_EN
      full = full + 64'(t_mem[j]);
`endif
      exp_q.push_back({IDX_W'(j), full[WORD_W-1:0]});
      carry = full[2*WORD_W-1:WORD_W];
    end
    exp_carry = carry;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_t();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Caller is 1ns after a rising edge; returns 1ns after the edge ending the last cycle.
  task automatic run_row(input string name, input logic [WORD_W-1:0] a,
                         input bit dup_start, input int tail);
    logic [EW-1:0] e;
    model_row(a);
    bus.start = 1'b1;
    bus.a_i   = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= NUM_WORDS + 2 + tail; c++) begin
      bus.a_i = $urandom;
      if (dup_start && c == 3) bus.start = 1'b1;
      else bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== (c <= NUM_WORDS + 2)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, bus.busy, (c <= NUM_WORDS + 2));
      end
      checks++;
      if (bus.done !== (c == NUM_WORDS + 2)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b want %b", name, c, bus.done, (c == NUM_WORDS + 2));
      end
      if (c >= NUM_WORDS + 2) begin
        checks++;
        if (bus.carry_out !== exp_carry) begin
          errors++;
          $display("FAIL %s carry_out cycle %0d: got %h want %h", name, c, bus.carry_out, exp_carry);
        end
      end
      if (bus.wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra write cycle %0d: got addr %0d data %h want none",
                   name, c, bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.wr_addr, bus.wr_data} !== e || c != int'(e[EW-1:WORD_W]) + 3) begin
            errors++;
            $display("FAIL %s write cycle %0d: got addr %0d data %h want addr %0d data %h cycle %0d",
                     name, c, bus.wr_addr, bus.wr_data, e[EW-1:WORD_W], e[WORD_W-1:0],
                     int'(e[EW-1:WORD_W]) + 3);
          end
        end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing writes: got %0d outstanding want 0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    load_req  = 1'b0;
    bus.start = 1'b0;
    bus.a_i   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy %b done %b rd_en %b wr_en %b state %0d want all 0",
               bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.dbg_state);
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr, bus.wr_data, bus.carry_out} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rd_addr %0d wr_addr %0d wr_data %h carry_out %h want all 0",
               bus.rd_addr, bus.wr_addr, bus.wr_data, bus.carry_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_pass_through();
    for (int j = 0; j < NUM_WORDS; j++) begin
      b_mem[j]  = $urandom;
      t_init[j] = WORD_W'(j + 1);
    end
    apply_t();
    run_row("pass_through", '0, 1'b0, 2);
  endtask

  task automatic test_small();
    b_mem[0] = 32'd5; b_mem[1] = 32'd7; b_mem[2] = '0; b_mem[3] = '0;
    for (int j = 0; j < NUM_WORDS; j++) t_init[j] = 32'd1;
    apply_t();
    run_row("small", 32'd3, 1'b0, 1);
  endtask

  task automatic test_all_ones();
    for (int j = 0; j < NUM_WORDS; j++) begin
      b_mem[j]  = '1;
      t_init[j] = '1;
    end
    apply_t();
    run_row("all_ones", '1, 1'b0, 2);
  endtask

  task automatic test_acc_off_vector();
    b_mem[0] = 32'h8000_0000; b_mem[1] = 32'd1; b_mem[2] = '0; b_mem[3] = '0;
    for (int j = 0; j < NUM_WORDS; j++) t_init[j] = $urandom;
    apply_t();
    run_row("carry_chain", 32'd2, 1'b0, 1);
  endtask

  task automatic test_start_while_busy();
    for (int j = 0; j < NUM_WORDS; j++) begin
      b_mem[j]  = $urandom;
      t_init[j] = $urandom;
    end
    apply_t();
    run_row("start_while_busy", $urandom, 1'b1, 3);
  endtask

  task automatic test_reset_mid_row();
    logic [WORD_W-1:0] a;
    for (int j = 0; j < NUM_WORDS; j++) begin
      b_mem[j]  = $urandom;
      t_init[j] = $urandom;
    end
    apply_t();
    a = $urandom;
    bus.start = 1'b1;
    bus.a_i   = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== IDX_W'(1)) begin
      errors++;
      $display("FAIL mid_row_write cycle 4: got wr_en %b addr %0d want 1 addr 1", bus.wr_en, bus.wr_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.dbg_state,
         bus.rd_addr, bus.wr_addr, bus.wr_data, bus.carry_out} !== '0) begin
      errors++;
      $display("FAIL mid_row_reset: got busy %b done %b rd_en %b wr_en %b state %0d wr_data %h carry_out %h want all 0",
               bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.dbg_state, bus.wr_data, bus.carry_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_row("after_reset", $urandom, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < NUM_WORDS; j++) begin
      b_mem[j]  = $urandom;
      t_init[j] = $urandom;
    end
    apply_t();
    run_row("b2b_row0", $urandom, 1'b0, 0);
    for (int j = 0; j < NUM_WORDS; j++) b_mem[j] = $urandom;
    run_row("b2b_row1", $urandom, 1'b0, 0);
    for (int j = 0; j < NUM_WORDS; j++) b_mem[j] = $urandom;
    run_row("b2b_row2", $urandom, 1'b0, 2);
  endtask

  task automatic test_random();
    logic [WORD_W-1:0] a;
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < NUM_WORDS; j++) begin
        b_mem[j]  = ($urandom_range(0, 3) == 0) ? '1 : WORD_W'($urandom);
        t_init[j] = ($urandom_range(0, 3) == 0) ? '1 : WORD_W'($urandom);
      end
      a = ($urandom_range(0, 3) == 0) ? '1 : WORD_W'($urandom);
      apply_t();
      run_row("random", a, $urandom_range(0, 1) == 1, $urandom_range(0, 2));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pass_through();
    test_small();
    test_all_ones();
    test_acc_off_vector();
    test_start_while_busy();
    test_reset_mid_row();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_add_row.md
# mul_add_row

Word-serial row sequencer for the Montgomery product datapath: for one multiplier word `a_i`, it computes T + a_i·B over NUM_WORDS words. It feeds the existing `MulAdd` cell one word per cycle (x = a_i, y = B[j], z = T[j], last_c = running carry). It writes each low word back to the T buffer and reports the final carry word. It sits between the operand RAMs and `MulAdd`; the MonPro controller issues one `start` per row.

## Interface
Parameters:
- `WORD_W`, 32: word width (matches `DATA_WIDTH`).
- `NUM_WORDS`, 128: words per operand row (4096/32).
- `IDX_W`, max(1, clog2(NUM_WORDS)): word index width (derived).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a row; sampled only in IDLE.
- `a_i` in WORD_W: multiplier word; captured on accepted `start`.
- `busy` out 1: high from the cycle after `start` until `done` inclusive.
- `done` out 1: one-cycle pulse; the row is complete.
- `rd_en` out 1: operand RAM read enable.
- `rd_addr` out IDX_W: shared read address for the B and T RAMs.
- `b_rdata` in WORD_W: B[rd_addr], valid 1 cycle after `rd_en`.
- `t_rdata` in WORD_W: T[rd_addr], valid 1 cycle after `rd_en`.
- `wr_en` out 1: T RAM write enable.
- `wr_addr` out IDX_W: T write address.
- `wr_data` out WORD_W: new T word (low half of `MulAdd`).
- `carry_out` out WORD_W: final carry word; valid with `done`, held until the next accepted `start`.

## Operation
- FSM states: IDLE, FETCH, RUN, LAST.
  - IDLE → FETCH on `start`. `a_i` is latched, the carry register is cleared, and the index is set to 0.
  - FETCH: `rd_en`=1, `rd_addr`=0 → RUN.
  - RUN: the data for index j is present. `MulAdd` computes s,c. s is registered into `wr_data` with `wr_addr`=j and `wr_en`=1 on the next cycle. c is registered into the carry register.
    - If j < NUM_WORDS−1: issue `rd_addr`=j+1 and stay in RUN.
    - If j = NUM_WORDS−1: → LAST.
  - LAST: the final write is presented, `done`=1 and `carry_out` = carry register → IDLE.
- Arithmetic: a_i·B[j] + T[j] + carry ≤ 2^(2·WORD_W)−1, so the result never overflows 2·WORD_W bits. `carry_out` is the exact high word.
- Read-before-write: `wr_addr` always trails `rd_addr` by ≥2, so the same RAM may serve T reads and writes (1R1W).
- `start` while `busy` is ignored; `a_i` is not re-latched.
- NUM_WORDS=1: FETCH → RUN (j=0) → LAST; legal.
- Reset (any state, mid-row included): FSM → IDLE, index 0, carry 0, `carry_out` 0, and `busy`/`done`/`rd_en`/`wr_en` 0. A partially written T buffer is left as is, and the controller restarts the row.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: FETCH, `rd_addr`=0.
- Cycles 2..NUM_WORDS+1: RUN.
- Writes occur in cycles 3..NUM_WORDS+2; the write for word j is in cycle j+3.
- `done`, `carry_out` valid and the last `wr_en` all fall in cycle NUM_WORDS+2.
- Row latency: NUM_WORDS+2 cycles from `start` to `done`.
- A new `start` is accepted in cycle NUM_WORDS+3 at the earliest, giving a throughput of 1 row per NUM_WORDS+3 cycles.
- Reset values: every output is 0.
- The `MulAdd` path is combinational between the RAM output and the `wr_data`/carry registers. That path is the critical path.

## Configuration
- `MUL_ADD_ROW_ACC_EN`
  - Defined: z = `t_rdata` (accumulate, T + a_i·B).
  - Undefined: z is tied to 0, `t_rdata` is unused and the row computes a_i·B only. Used for the first row of MonPro, where T = 0. Timing and handshake are identical in both builds.

## Structure
- Shared parameter include (`_parameter.v` style) holds:
  - `WORD_W`/`DATA_WIDTH`
  - `NUM_WORDS`
  - FSM state encodings (IDLE=0, FETCH=1, RUN=2, LAST=3)
- One sub-module: the existing `MulAdd`, instantiated once. The FSM, index counter and output registers live in `mul_add_row`.

## Test plan
- WORD_W=32, NUM_WORDS=4, ACC enabled, a_i=0, T={1,2,3,4} → writes {1,2,3,4} to addr 0..3, `carry_out`=0, `done` in cycle 6.
- a_i=3, B={5,7,0,0}, T={1,1,1,1} → writes {16,22,1,1}, `carry_out`=0.
- a_i, B, T all 0xFFFFFFFF → writes {0x0, 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF}, `carry_out`=0xFFFFFFFF.
- ACC disabled, a_i=2, B={0x80000000,1,0,0}, T=garbage → writes {0,3,0,0}, `carry_out`=0.
- Pulse `start` in cycle 3 while busy with a different `a_i` → ignored; results match the first `a_i`; `done` only once.
- Assert `reset` in cycle 4 of a row → all outputs 0 immediately; a following `start` completes a correct row with `done` NUM_WORDS+2 cycles later.
